// File: rtl/c_fft_pkg.sv
// Shared constants and types for the FFT coefficient path.
package c_fft_pkg;

  localparam int C_N     = 16;
  localparam int C_MSB   = 16;
  localparam int N_BFLY  = C_N / 2;
  localparam int SEL_W   = 2;
  localparam logic [SEL_W-1:0] SLOT_LAST = 2'd2;

  typedef struct packed {
    logic [C_MSB-1:0] c0;
    logic [C_MSB-1:0] c1;
    logic [C_MSB-1:0] c2;
  } coef_bundle_t;

  typedef enum logic [SEL_W-1:0] {
    EXP_S0 = 2'd0,
    EXP_S1 = 2'd1,
    EXP_S2 = 2'd2
  } exp_e;

endpackage

// File: rtl/c_bundle_fifo.sv
// Two-entry FIFO with head-of-queue output; a push while full is accepted
// only when a pop happens in the same cycle, otherwise it is dropped.
module c_bundle_fifo #(
  parameter int W = 48
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_q, wr_d;
  logic         rd_q, rd_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_push, do_pop;

  assign full  = (cnt_q == 2'd2);
  assign empty = (cnt_q == 2'd0);
  assign head  = mem_q[rd_q];

  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    mem_d   = mem_q;
    if (do_push) begin
      mem_d[wr_q] = push_data;
    end
    wr_d  = wr_q ^ do_push;
    rd_d  = rd_q ^ do_pop;
    cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/c_collector.sv
// Regroups the mapper's coefficient read stream into 3-word butterfly bundles.
// Optional bundle-count check on in_dv: define C_COLLECT_COUNT_CHECK_EN.
//
// state  | meaning
// EXP_S0 | waiting for slot 0 (also swallows the held slot-2 repeat)
// EXP_S1 | slot 0 stored, waiting for slot 1
// EXP_S2 | slots 0,1 stored, slot 2 completes the bundle
module c_collector
  import c_fft_pkg::*;
#(
  parameter int N   = 2 * N_BFLY,
  parameter int MSB = C_MSB
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_we,
  input  logic [SEL_W-1:0] in_sel,
  input  logic [MSB-1:0]   in_data,
  input  logic             in_dv,
  output logic [MSB-1:0]   out_c0,
  output logic [MSB-1:0]   out_c1,
  output logic [MSB-1:0]   out_c2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             stage_done,
  output logic             ovf_err,
  output logic             seq_err
`ifdef C_COLLECT_COUNT_CHECK_EN
  ,
  output logic             cnt_err
`endif
);

  localparam int BFLY = N / 2;
  localparam int DW   = (BFLY > 1) ? $clog2(BFLY) : 1;

  logic             we_dly_q, we_dly_d;
  logic [SEL_W-1:0] sel_dly_q, sel_dly_d;
  exp_e             exp_q, exp_d;
  logic [MSB-1:0]   c0_q, c0_d;
  logic [MSB-1:0]   c1_q, c1_d;
  logic             cap, sel_match, held_last;
  logic             store_c0, store_c1, complete, seq_set;
  coef_bundle_t     push_bundle, head_bundle;
  logic             fifo_full, fifo_empty, pop;
  logic [DW-1:0]    done_cnt_q, done_cnt_d;
  logic             stage_done_q, stage_done_d;
  logic             ovf_q, ovf_d;
  logic             seq_q, seq_d;

  assign cap       = we_dly_q;
  assign sel_match = (sel_dly_q == SEL_W'(exp_q));
  assign held_last = (sel_dly_q == SLOT_LAST) && (exp_q == EXP_S0);

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q <= EXP_S0;
    end else begin
      exp_q <= exp_d;
    end
  end

  always_comb begin
    exp_d = exp_q;
    if (cap) begin
      if (sel_match) begin
        case (exp_q)
          EXP_S0:  exp_d = EXP_S1;
          EXP_S1:  exp_d = EXP_S2;
          default: exp_d = EXP_S0;
        endcase
      end else if (held_last) begin
        exp_d = exp_q;
      end else if (sel_dly_q == '0) begin
        exp_d = EXP_S1;
      end else begin
        exp_d = EXP_S0;
      end
    end
    // end-of-stage drops any partial bundle but keeps a completion in the same cycle
    if (in_dv) begin
      exp_d = EXP_S0;
    end
  end

  always_comb begin
    store_c0 = cap && (sel_dly_q == '0);
    store_c1 = cap && sel_match && (exp_q == EXP_S1);
    complete = cap && sel_match && (exp_q == EXP_S2);
    seq_set  = cap && !sel_match && !held_last;
  end

  always_comb begin
    we_dly_d       = in_we;
    sel_dly_d      = in_sel;
    c0_d           = store_c0 ? in_data : c0_q;
    c1_d           = store_c1 ? in_data : c1_q;
    push_bundle.c0 = c0_q;
    push_bundle.c1 = c1_q;
    push_bundle.c2 = in_data;
    pop            = !fifo_empty && out_ready;
    ovf_d          = ovf_q | (complete && fifo_full && !pop);
    seq_d          = seq_q | seq_set;
    done_cnt_d     = done_cnt_q;
    stage_done_d   = 1'b0;
    if (pop) begin
      if (done_cnt_q == DW'(BFLY - 1)) begin
        done_cnt_d   = '0;
        stage_done_d = 1'b1;
      end else begin
        done_cnt_d = done_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_dly_q     <= 1'b0;
      sel_dly_q    <= '0;
      c0_q         <= '0;
      c1_q         <= '0;
      done_cnt_q   <= '0;
      stage_done_q <= 1'b0;
      ovf_q        <= 1'b0;
      seq_q        <= 1'b0;
    end else begin
      we_dly_q     <= we_dly_d;
      sel_dly_q    <= sel_dly_d;
      c0_q         <= c0_d;
      c1_q         <= c1_d;
      done_cnt_q   <= done_cnt_d;
      stage_done_q <= stage_done_d;
      ovf_q        <= ovf_d;
      seq_q        <= seq_d;
    end
  end

  c_bundle_fifo #(
    .W($bits(coef_bundle_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (complete),
    .push_data (push_bundle),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head_bundle)
  );

  assign out_c0     = head_bundle.c0;
  assign out_c1     = head_bundle.c1;
  assign out_c2     = head_bundle.c2;
  assign out_valid  = !fifo_empty;
  assign stage_done = stage_done_q;
  assign ovf_err    = ovf_q;
  assign seq_err    = seq_q;

`ifdef C_COLLECT_COUNT_CHECK_EN
  localparam int CW = $clog2(BFLY + 1) + 1;

  logic [CW-1:0] bcnt_q, bcnt_d, bcnt_next;
  logic          cnt_err_q, cnt_err_d;

  always_comb begin
    bcnt_next = bcnt_q;
    if (complete && (bcnt_q != '1)) begin
      bcnt_next = bcnt_q + 1'b1;
    end
    bcnt_d    = bcnt_next;
    cnt_err_d = cnt_err_q;
    if (in_dv) begin
      cnt_err_d = cnt_err_q | (bcnt_next != CW'(BFLY));
      bcnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt_q    <= '0;
      cnt_err_q <= 1'b0;
    end else begin
      bcnt_q    <= bcnt_d;
      cnt_err_q <= cnt_err_d;
    end
  end

  assign cnt_err = cnt_err_q;
`endif

endmodule

// File: doc/c_collector.md
Name: c_collector

Overview:
- Receiving end of the twiddle-coefficient stream produced by the coefficient mapper for one FFT stage.
- Accepts the mapper's coefficient-RAM read stream (one word per cycle, tagged by a 2-bit select) and regroups every three consecutive words into one butterfly coefficient bundle.
- Queues bundles in a 2-entry FIFO and hands them to the butterfly datapath over a valid/ready handshake.
- Reports end-of-stage and protocol errors.

Parameters:
- N, 16: FFT size; one stage carries N/2 butterflies, so N/2 bundles.
- MSB, 16: coefficient word width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- in_we  in  1  mapper read-enable; the RAM word for the current select appears on in_data one cycle later
- in_sel  in  2  mapper select; slot index 0,1,2 of the word being read
- in_data  in  MSB  coefficient RAM read data, one cycle behind in_we/in_sel
- in_dv  in  1  mapper end-of-stage pulse
- out_c0, out_c1, out_c2  out  MSB each  coefficient bundle: slots 0, 1 and 2
- out_valid  out  1  bundle available at the FIFO head
- out_ready  in  1  consumer accepts the head bundle
- stage_done  out  1  one-cycle pulse: all N/2 bundles of the stage have been accepted downstream
- ovf_err  out  1  sticky: a bundle completed while the FIFO was full; that bundle is dropped
- seq_err  out  1  sticky: a select arrived out of order

Behaviour:
- Reset: all outputs 0, FIFO empty, expected slot 0, bundle counters 0. Reset mid-stage discards any partial bundle and all queued bundles.
- Alignment:
  - in_we and in_sel are registered once (we_d, sel_d).
  - A capture happens in cycle t+1 when we_d=1, writing in_data into slot sel_d.
- Slot sequencer (exp = 0, 1, 2):
  - Capture with sel_d==exp: store the word; exp advances 0→1→2→0.
  - Bundle completes on the slot-2 capture with exp==2.
  - Capture with sel_d==2 and exp==0: a repeated slot 2 (the mapper holds select=2 for one extra cycle at stage end). Ignore it; no error.
  - Capture with sel_d==0 and exp≠0: discard the partial bundle, store as slot 0, set exp=1, set seq_err.
  - Any other mismatch: discard the partial bundle, set exp=0, set seq_err.
  - in_sel==3 is always a mismatch.
- FIFO: 2 entries of 3×MSB bits.
  - Push on bundle completion; pop when out_valid && out_ready.
  - Push and pop in the same cycle are both legal when full.
  - Push while full without a pop: bundle dropped, ovf_err set.
  - out_c* show the head entry, registered; out_valid=1 when the FIFO is non-empty.
  - A bundle completing into an empty FIFO is visible on out_valid in the next cycle. Latency from slot-2 word on in_data to out_valid is 1 cycle.
- Done counter: counts pops 0..N/2-1.
  - On the pop that brings the count to N/2, pulse stage_done and clear the count.
- in_dv: resets exp to 0 and discards any partial bundle; it does not flush the FIFO.
- Error flags: clear only on rst.

Optional Feature:
- Macro C_COLLECT_COUNT_CHECK_EN.
- When defined:
  - A second counter counts completed bundles (pushes, including dropped ones) since the last in_dv.
  - On in_dv, if that count ≠ N/2, cnt_err (extra 1-bit sticky output) is set; the counter then clears.
- When undefined: no counter and no cnt_err port; in_dv behaves as above.

Decomposition:
- Shared package c_fft_pkg:
  - Constants N_BFLY=N/2, SEL_W=2, SLOT_LAST=2.
  - Typedef coef_bundle_t {c0, c1, c2}.
- Sub-module c_bundle_fifo: 2-deep, width-parameterised, with push/pop/full/empty. It is reused later for butterfly outputs.

Test Plan:
- Nominal stage, N=16, out_ready=1, mapper sequence including the held select=2 at the end -> 8 bundles. Bundle 0 = (16'h007f, 16'h0075, 16'h0059) when RAM returns those words. One stage_done pulse after the 8th pop; seq_err=0.
- out_ready=0 for the whole stage -> FIFO holds bundles 0 and 1; bundle 2 completion sets ovf_err. Releasing out_ready then yields bundles 0 and 1 in order.
- in_sel sequence 0,1,0,1,2 -> seq_err=1; exactly one bundle is pushed, built from the second 0,1,2 words.
- rst asserted after slot 1 of bundle 3 -> all outputs 0 next cycle. A following full stage produces 8 clean bundles and stage_done.
- Full FIFO with a simultaneous completion and pop -> no ovf_err; the order of out_c* is preserved.
- With C_COLLECT_COUNT_CHECK_EN, in_dv after only 5 bundles -> cnt_err=1. A following correct stage leaves cnt_err=1 (sticky).
